// File: rtl/sel_arb_pkg.sv
// Shared sizes, state type and helpers for the select-code arbiter.
package sel_arb_pkg;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned SEL_W = 2;

   typedef enum logic [0:0] {
      IDLE,
      GRANT
   } arb_state_t;

   function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] code);
      logic [NREQ-1:0] v;
      v       = '0;
      v[code] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/sel_rr_pick.sv
// Round-robin search: first set bit of mask starting at (last+1) mod NREQ, wrapping.
module sel_rr_pick
   import sel_arb_pkg::*;
(
   input  logic [NREQ-1:0]  mask,
   input  logic [SEL_W-1:0] last,
   output logic             any,
   output logic [SEL_W-1:0] winner
);

   always_comb begin
      any    = 1'b0;
      winner = '0;
      // i == NREQ wraps back to last itself, so it is searched last
      for (int unsigned i = 1; i <= NREQ; i++) begin
         if (!any && mask[last + SEL_W'(i)]) begin
            any    = 1'b1;
            winner = last + SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/sel_arbiter.sv
// Four-source round-robin arbiter with hold limit and lock; all outputs registered.
module sel_arbiter
   import sel_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   input  logic             lock,
   output logic [SEL_W-1:0] sel,
   output logic             gnt_valid,
   output logic [NREQ-1:0]  gnt
);

   arb_state_t       state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] last_q, last_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [3:0]       hold_q, hold_d;

   logic [NREQ-1:0]  pick_mask;
   logic             pick_any;
   logic [SEL_W-1:0] pick_code;
   logic             owner_req;
   logic             release_grant;

   assign owner_req = req[sel_q];
   // >= so an owner that held past the limit under lock releases as soon as lock drops
   assign release_grant = !owner_req || ((hold_q >= 4'(MAX_HOLD)) && !lock);
   assign pick_mask = (state_q == GRANT) ? (req & ~onehot(sel_q)) : req;

   sel_rr_pick u_pick (
      .mask   (pick_mask),
      .last   (last_q),
      .any    (pick_any),
      .winner (pick_code)
   );

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      last_d      = last_q;
      gnt_valid_d = gnt_valid_q;
      hold_d      = hold_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d     = GRANT;
               sel_d       = pick_code;
               last_d      = pick_code;
               gnt_valid_d = 1'b1;
               hold_d      = 4'd1;
            end else begin
               gnt_valid_d = 1'b0;
               hold_d      = 4'd0;
            end
         end
         GRANT: begin
            if (!release_grant) begin
               if (hold_q != 4'hf) hold_d = hold_q + 4'd1;
            end else if (pick_any) begin
               sel_d  = pick_code;
               last_d = pick_code;
               hold_d = 4'd1;
            end else if (owner_req) begin
               hold_d = 4'd1;
            end else begin
               state_d     = IDLE;
               gnt_valid_d = 1'b0;
               hold_d      = 4'd0;
            end
         end
         default: begin
            state_d     = IDLE;
            gnt_valid_d = 1'b0;
         end
      endcase
      gnt_d = gnt_valid_d ? onehot(sel_d) : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         last_q      <= SEL_W'(NREQ - 1);
         gnt_valid_q <= 1'b0;
         gnt_q       <= '0;
         hold_q      <= 4'd0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         last_q      <= last_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_q       <= gnt_d;
         hold_q      <= hold_d;
      end
   end

   assign sel       = sel_q;
   assign gnt_valid = gnt_valid_q;
   assign gnt       = gnt_q;

endmodule

// File: tb/tb_sel_arbiter.sv
// Bench for sel_arbiter: directed scenarios with literal expectations plus a random run
// checked every cycle against a behavioural owner/run-length model.
module tb_sel_arbiter;

   localparam int unsigned MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       lock;
   logic [3:0] req;
   logic [1:0] sel;
   logic       gnt_valid;
   logic [3:0] gnt;

   int n_vec = 0;
   int n_err = 0;

   sel_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .lock      (lock),
      .sel       (sel),
      .gnt_valid (gnt_valid),
      .gnt       (gnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Downstream case-mux: a=1, b=2, c=3
   function automatic logic [7:0] mux_byte(input logic [1:0] code);
      case (code)
         2'd0:       return 8'd1;
         2'd1, 2'd2: return 8'd2;
         2'd3:       return 8'd3;
         default:    return 8'hxx;
      endcase
   endfunction

   // Reference model: current owner (-1 = none), length of its current run, last winner.
   int  m_owner = -1;
   int  m_run   = 0;
   int  m_last  = 3;
   int  m_sel   = 0;
   bit  model_on = 1'b0;
   int  w;
   bit  expire;

   function automatic int rr(input logic [3:0] mask, input int last);
      for (int k = 1; k <= 4; k++) begin
         if (mask[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_owner  = -1;
         m_run    = 0;
         m_last   = 3;
         m_sel    = 0;
         model_on = 1'b1;
      end else if (m_owner < 0) begin
         w = rr(req, m_last);
         if (w >= 0) begin
            m_owner = w;
            m_run   = 1;
            m_last  = w;
            m_sel   = w;
         end
      end else begin
         expire = (m_run >= MAX_HOLD) && !lock;
         if (req[m_owner] && !expire) begin
            m_run++;
         end else begin
            w = rr(req & ~(4'd1 << m_owner), m_last);
            if (w >= 0) begin
               m_owner = w;
               m_run   = 1;
               m_last  = w;
               m_sel   = w;
            end else if (req[m_owner]) begin
               m_run = 1;
            end else begin
               m_owner = -1;
            end
         end
      end
   end

   logic [7:0] byte_tab [4] = '{8'd1, 8'd2, 8'd2, 8'd3};

   always @(negedge clk) begin
      if (model_on) begin
         check("sel", 32'(sel), 32'(m_sel));
         check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
         check("gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_sel) : 32'd0);
         check("gnt_vs_sel", 32'(gnt), gnt_valid ? (32'd1 << sel) : 32'd0);
         check("mux_byte", 32'(mux_byte(sel)), 32'(byte_tab[m_sel]));
      end
   end

   int exp29 [20] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0, 0, 0, 0};

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = 4'b0000;
      lock  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 4'b0000;
      lock  = 1'b0;

      // Single requester: re-granted continuously
      do_reset();
      check("rst_valid", 32'(gnt_valid), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_gnt", 32'(gnt), 32'd0);
      req = 4'b0001;
      repeat (10) begin
         @(negedge clk);
         check("solo_valid", 32'(gnt_valid), 32'd1);
         check("solo_sel", 32'(sel), 32'd0);
         check("solo_gnt", 32'(gnt), 32'b0001);
      end

      // All requesting: fair rotation, MAX_HOLD each
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("rot_sel", 32'(sel), 32'(exp29[i]));
         check("rot_valid", 32'(gnt_valid), 32'd1);
      end

      // Lock holds owner past the limit; release when lock drops
      do_reset();
      req  = 4'b0101;
      lock = 1'b1;
      repeat (8) begin
         @(negedge clk);
         check("lock_sel", 32'(sel), 32'd0);
      end
      lock = 1'b0;
      @(negedge clk);
      check("unlock_sel", 32'(sel), 32'd2);

      // Owner drops request exactly at hold expiry: single release
      do_reset();
      req = 4'b0010;
      @(negedge clk);
      check("own1_sel", 32'(sel), 32'd1);
      req = 4'b1010;
      repeat (3) begin
         @(negedge clk);
         check("nopreempt_sel", 32'(sel), 32'd1);
      end
      req = 4'b1000;
      @(negedge clk);
      check("drop_sel", 32'(sel), 32'd3);
      check("drop_gnt", 32'(gnt), 32'b1000);

      // Reset during a grant, then search restarts from 0
      do_reset();
      req = 4'b0100;
      @(negedge clk);
      check("pre_sel", 32'(sel), 32'd2);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_valid", 32'(gnt_valid), 32'd0);
      check("midrst_sel", 32'(sel), 32'd0);
      rst_n = 1'b1;
      req   = 4'b1100;
      @(negedge clk);
      check("postrst_sel", 32'(sel), 32'd2);

      // Random traffic checked by the model every cycle
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         if ($urandom_range(0, 7) == 0) lock = 1'($urandom_range(0, 1));
      end

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sel_arbiter.md
SEL_ARBITER -- requirements
Module: sel_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4: maximum consecutive grant cycles per owner when lock is low; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req  input  4  per-source request; bit i requests select code i.
REQ-005 lock  input  1  current owner holds its grant past MAX_HOLD while high.
REQ-006 sel  output  2  registered select code for the downstream case-mux; 0=a, 1/2=b, 3=c.
REQ-007 gnt_valid  output  1  registered; sel is a valid grant this cycle.
REQ-008 gnt  output  4  registered one-hot grant; equals (1<<sel) when gnt_valid, else 0.

Function
REQ-009 FSM states SHALL be IDLE and GRANT only.
REQ-010 IDLE, req==0: stay IDLE, gnt_valid=0, sel unchanged.
REQ-011 IDLE, req!=0: pick winner round-robin, searching from (last+1) mod 4 upward with wrap; load sel, set gnt_valid, enter GRANT on the next edge (1-cycle req-to-grant latency).
REQ-012 last SHALL be the most recent granted code; reset value 3, so the first search starts at 0.
REQ-013 GRANT: hold_cnt (4 bits) SHALL be 1 in the first grant cycle and increment each further grant cycle, saturating at 15.
REQ-014 GRANT release condition: req[sel]==0, OR (hold_cnt==MAX_HOLD AND lock==0).
REQ-015 On release with other requests pending (req with bit sel masked != 0): re-arbitrate in the same edge, grant the new winner with no idle gap, hold_cnt=1.
REQ-016 On release with no other requests pending: if req[sel] still high, re-grant the same source (hold_cnt=1); else enter IDLE, gnt_valid=0.
REQ-017 lock high: owner keeps grant regardless of hold_cnt until req[sel] drops; lock SHALL be ignored in IDLE.
REQ-018 Arbitration SHALL be fair: with all four requesting continuously and lock low, grants rotate 0,1,2,3,0,... each lasting exactly MAX_HOLD cycles.
REQ-019 Simultaneous req[sel] drop and hold expiry: treated as a single release (REQ-015/016), no double advance of last.
REQ-020 sel SHALL never change while gnt_valid is high except on a release edge; gnt SHALL always be one-hot or zero.
REQ-021 Requests arriving mid-grant SHALL NOT preempt the owner.

Reset
REQ-022 When rst_n==0 at a clock edge: state=IDLE, sel=0, gnt_valid=0, gnt=0, hold_cnt=0, last=3.
REQ-023 Reset asserted mid-grant SHALL drop gnt_valid on that edge; the first grant after reset deasserts follows REQ-011 with last=3.
REQ-024 Outputs SHALL be X-free from the first edge with rst_n low.

Structure
REQ-025 Package sel_arb_pkg SHALL hold NREQ=4, SEL_W=2, and the enum type arb_state_t {IDLE, GRANT}.
REQ-026 Round-robin search SHALL be a combinational sub-module sel_rr_pick (inputs: req mask, last; outputs: any, winner code), instantiated once.
REQ-027 All outputs SHALL come directly from flops; no combinational path from req or lock to sel/gnt/gnt_valid.

Verification
REQ-028 Reset then req=4'b0001 held 10 cycles, MAX_HOLD=4, lock=0 -> gnt_valid rises 1 cycle after req, sel=0 continuously (REQ-016 re-grant), gnt=4'b0001.
REQ-029 req=4'b1111 held 20 cycles, MAX_HOLD=4 -> sel sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0..., no gnt_valid gap.
REQ-030 req=4'b0101, lock=1 for 8 cycles -> sel=0 for 8 cycles; lock drops -> sel=2 on next edge once hold_cnt>=MAX_HOLD.
REQ-031 Owner sel=1 drops req[1] on the cycle hold_cnt==MAX_HOLD with req[3] pending -> single release, sel=3 next cycle, last=3.
REQ-032 rst_n low for 1 cycle during sel=2 grant -> gnt_valid=0, sel=0 after that edge; req=4'b1100 after -> sel=2 (search from 0).
REQ-033 All scenarios: assertion that gnt==(gnt_valid ? 1<<sel : 0) every cycle; sel drives the a/b/c case-mux and selected byte matches 1/2/2/3 for codes 0/1/2/3.
